// File: rtl/kgprisc_run_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module   : kgprisc_run_ctrl_if
//  Brief    : Program-load stream and instruction-memory write port bundle
//             shared by the KGPRISC run controller and its host/memory side.
//  Revision : 1.0 - initial release
// ============================================================================
interface kgprisc_run_ctrl_if #(
  parameter int ADDR_W = 10
);
  // Host -> controller program stream
  logic              ld_valid;
  logic [31:0]       ld_data;
  logic              ld_last;
  logic              ld_ready;

  // Controller -> instruction memory write port
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_wdata;

  // Host / memory side
  modport master (
    output ld_valid, ld_data, ld_last,
    input  ld_ready, imem_we, imem_addr, imem_wdata
  );

  // Run controller side
  modport slave (
    input  ld_valid, ld_data, ld_last,
    output ld_ready, imem_we, imem_addr, imem_wdata
  );
endinterface
`default_nettype wire

// File: rtl/kgprisc_run_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : kgprisc_run_ctrl
//  Brief    : Loads a program into KGPRISC instruction memory, primes the
//             core, runs it free-running or single-step until HALT or a cycle
//             limit, then freezes the core for inspection.
//  Revision : 1.0 - initial release
// ============================================================================
module kgprisc_run_ctrl #(
  parameter int          ADDR_W     = 10,
  parameter logic [31:0] HALT_WORD  = 32'hFFFF_FFFF,
  parameter int          CNT_W      = 32,
  parameter int          MAX_CYCLES = 100000
) (
  input  logic                clk,
  input  logic                rst,
  kgprisc_run_ctrl_if.slave   bus,
  input  logic                start,
  input  logic                step_mode,
  input  logic                step,
  input  logic [31:0]         instruction,
  output logic                cpu_hold_rst,
  output logic                cpu_en,
  output logic                busy,
  output logic                done,
  output logic                timeout,
  output logic                overflow,
  output logic [CNT_W-1:0]    cycles,
  output logic [ADDR_W:0]     load_count
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_PRIME = 3'd2,
    S_RUN   = 3'd3,
    S_STEP  = 3'd4,
    S_DONE  = 3'd5
  } state_t;

  localparam logic [ADDR_W-1:0] C_ADDR_MAX = {ADDR_W{1'b1}};
  localparam logic [ADDR_W-1:0] C_PTR_ONE  = ADDR_W'(1);
  localparam logic [ADDR_W:0]   C_LC_ONE   = (ADDR_W+1)'(1);
  localparam logic [CNT_W-1:0]  C_CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0]  C_MAX_CYC  = CNT_W'(MAX_CYCLES);

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   ptr_q, ptr_d;
  logic [ADDR_W:0]     load_count_q, load_count_d;
  logic                we_q, we_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [31:0]         wdata_q, wdata_d;
  logic [CNT_W-1:0]    cycles_q, cycles_d;
  logic                timeout_q, timeout_d;
  logic                overflow_q, overflow_d;
  logic                step_mode_q, step_mode_d;

  logic                w_ld_ready;
  logic                w_accept;
  logic                w_halt;
  logic                w_run_en;
  logic [CNT_W-1:0]    w_cyc_inc;

  assign w_ld_ready = (state_q == S_IDLE) || (state_q == S_LOAD) || (state_q == S_DONE);
  assign w_accept   = bus.ld_valid && w_ld_ready;
  assign w_halt     = (instruction == HALT_WORD);
  assign w_cyc_inc  = cycles_q + C_CNT_ONE;
  // A HALT word is never executed, even when a step request arrives with it.
  assign w_run_en   = !w_halt && ((state_q == S_RUN) || ((state_q == S_STEP) && step));

  // Next-state, datapath updates and core control decode
  always_comb begin
    state_d      = state_q;
    ptr_d        = ptr_q;
    load_count_d = load_count_q;
    we_d         = 1'b0;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    cycles_d     = cycles_q;
    timeout_d    = timeout_q;
    overflow_d   = overflow_q;
    step_mode_d  = step_mode_q;
    cpu_hold_rst = 1'b1;
    cpu_en       = 1'b0;
    busy         = 1'b0;

    unique case (state_q)
      S_IDLE, S_DONE: begin
        // DONE releases reset but keeps the clock stopped so results stay visible
        cpu_hold_rst = (state_q == S_IDLE);
        if (w_accept) begin
          // A new program always starts at address 0; load takes priority over start
          we_d         = 1'b1;
          addr_d       = '0;
          wdata_d      = bus.ld_data;
          ptr_d        = C_PTR_ONE;
          load_count_d = C_LC_ONE;
          cycles_d     = '0;
          timeout_d    = 1'b0;
          overflow_d   = 1'b0;
          state_d      = bus.ld_last ? S_IDLE : S_LOAD;
        end else if (start) begin
          cycles_d     = '0;
          timeout_d    = 1'b0;
          step_mode_d  = step_mode;
          state_d      = S_PRIME;
        end
      end

      S_LOAD: begin
        busy = 1'b1;
        if (w_accept) begin
          we_d         = 1'b1;
          addr_d       = ptr_q;
          wdata_d      = bus.ld_data;
          ptr_d        = ptr_q + C_PTR_ONE;
          load_count_d = load_count_q + C_LC_ONE;
          if (bus.ld_last) begin
            state_d = S_IDLE;
          end else if (ptr_q == C_ADDR_MAX) begin
            // Memory full: close the load and flag the surplus
            overflow_d = 1'b1;
            state_d    = S_IDLE;
          end
        end
      end

      S_PRIME: begin
        // Reset plus enable for one edge clears the core PC
        busy    = 1'b1;
        cpu_en  = 1'b1;
        state_d = step_mode_q ? S_STEP : S_RUN;
      end

      S_RUN, S_STEP: begin
        busy         = 1'b1;
        cpu_hold_rst = 1'b0;
        cpu_en       = w_run_en;
        if (w_halt) begin
          state_d = S_DONE;
        end else if (w_run_en) begin
          if (cycles_q != C_MAX_CYC) begin
            cycles_d = w_cyc_inc;
          end
          if (w_cyc_inc == C_MAX_CYC) begin
            timeout_d = 1'b1;
            state_d   = S_DONE;
          end
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Load pointer, write port, counters and status flags; reset drops any pending write
  always_ff @(posedge clk) begin
    if (!rst) begin
      ptr_q        <= '0;
      load_count_q <= '0;
      we_q         <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      cycles_q     <= '0;
      timeout_q    <= 1'b0;
      overflow_q   <= 1'b0;
      step_mode_q  <= 1'b0;
    end else begin
      ptr_q        <= ptr_d;
      load_count_q <= load_count_d;
      we_q         <= we_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      cycles_q     <= cycles_d;
      timeout_q    <= timeout_d;
      overflow_q   <= overflow_d;
      step_mode_q  <= step_mode_d;
    end
  end

  assign bus.ld_ready   = w_ld_ready;
  assign bus.imem_we    = we_q;
  assign bus.imem_addr  = addr_q;
  assign bus.imem_wdata = wdata_q;
  assign done           = (state_q == S_DONE);
  assign timeout        = timeout_q;
  assign overflow       = overflow_q;
  assign cycles         = cycles_q;
  assign load_count     = load_count_q;

endmodule
`default_nettype wire

// File: tb/tb_kgprisc_run_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_kgprisc_run_ctrl
//  Brief    : Self-checking bench for kgprisc_run_ctrl with a tiny core model
//             (PC + instruction memory) and a program-walk reference model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_kgprisc_run_ctrl;

  localparam int          ADDR_W     = 2;
  localparam int          DEPTH      = 1 << ADDR_W;
  localparam int          CNT_W      = 32;
  localparam int          MAX_CYCLES = 8;
  localparam logic [31:0] HALT       = 32'hFFFF_FFFF;
  localparam logic [31:0] BSELF      = 32'hB000_0000;  // branch-to-self

  logic              clk = 1'b0;
  logic              rst;
  logic              start, step_mode, step;
  logic [31:0]       instruction;
  logic              cpu_hold_rst, cpu_en, busy, done, timeout, overflow;
  logic [CNT_W-1:0]  cycles;
  logic [ADDR_W:0]   load_count;

  kgprisc_run_ctrl_if #(.ADDR_W(ADDR_W)) bus ();

  kgprisc_run_ctrl #(
    .ADDR_W(ADDR_W), .HALT_WORD(HALT), .CNT_W(CNT_W), .MAX_CYCLES(MAX_CYCLES)
  ) dut (
    .clk(clk), .rst(rst), .bus(bus),
    .start(start), .step_mode(step_mode), .step(step), .instruction(instruction),
    .cpu_hold_rst(cpu_hold_rst), .cpu_en(cpu_en), .busy(busy), .done(done),
    .timeout(timeout), .overflow(overflow), .cycles(cycles), .load_count(load_count)
  );

  always #5 clk = ~clk;

  // Core model: instruction memory written by the controller, PC stepped by cpu_en
  logic [31:0]       imem [DEPTH] = '{default: 32'h0};
  logic [ADDR_W-1:0] pc = '0;
  int                cyc = 0;

  assign instruction = imem[pc];

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (bus.imem_we === 1'b1) imem[bus.imem_addr] <= bus.imem_wdata;
    if (cpu_hold_rst === 1'b1) begin
      if (cpu_en === 1'b1) pc <= '0;
    end else if (cpu_en === 1'b1) begin
      if (instruction != BSELF) pc <= pc + 1'b1;
    end
  end

  // Write and execution monitor
  typedef struct { int c; logic [ADDR_W-1:0] a; logic [31:0] d; } wr_t;
  wr_t wq[$];
  int  en_cnt = 0;

  always @(negedge clk) begin
    if (bus.imem_we === 1'b1) wq.push_back('{cyc, bus.imem_addr, bus.imem_wdata});
    if (cpu_en === 1'b1 && cpu_hold_rst === 1'b0) en_cnt <= en_cnt + 1;
  end

  // Reference state: what instruction memory should hold
  logic [31:0] mdl_mem [DEPTH] = '{default: 32'h0};
  logic [31:0] pw [8];
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Executes the program from address 0: counts retired instructions up to HALT or the limit
  function automatic void walk(output int n, output bit to);
    int p;
    p  = 0;
    n  = 0;
    to = 1'b0;
    for (int g = 0; g <= MAX_CYCLES; g++) begin
      if (mdl_mem[p] == HALT) return;
      n++;
      if (n == MAX_CYCLES) begin
        to = 1'b1;
        return;
      end
      if (mdl_mem[p] != BSELF) p = (p + 1) % DEPTH;
    end
  endfunction

  // Streams pw[0..n-1]; words beyond the memory are not offered in this load
  task automatic load_prog(input int n, input bit last, input bit gaps,
                           input bit start_first, input bit poke_start);
    int  n_acc, base, g;
    bit  exp_ovf;
    n_acc   = (n > DEPTH) ? DEPTH : n;
    exp_ovf = (n_acc == DEPTH) && !(last && n == DEPTH);
    base    = wq.size();
    for (int i = 0; i < n_acc; i++) begin
      if (gaps) begin
        g = $urandom_range(0, 2);
        bus.ld_valid = 1'b0;
        repeat (g) tick();
      end
      bus.ld_valid = 1'b1;
      bus.ld_data  = pw[i];
      bus.ld_last  = last && (i == n - 1);
      if (i == 0) start = start_first;
      check("ld_ready", bus.ld_ready, 1'b1);
      tick();
      start        = 1'b0;
      bus.ld_valid = 1'b0;
      if (i == 0 && start_first) check("load_beats_start", cpu_en, 1'b0);
      if (i == 0 && poke_start && n_acc > 1) begin
        start = 1'b1;
        tick();
        start = 1'b0;
        check("start_in_load", {busy, cpu_en}, 2'b10);
      end
    end
    tick();
    tick();
    check("wr_count", wq.size() - base, n_acc);
    for (int i = 0; i < n_acc; i++) begin
      if (base + i < wq.size()) begin
        check("wr_addr", wq[base+i].a, i);
        check("wr_data", wq[base+i].d, pw[i]);
      end
      mdl_mem[i] = pw[i];
    end
    if (!gaps && !poke_start && n_acc > 1 && wq.size() == base + n_acc)
      check("wr_b2b", wq[base+n_acc-1].c - wq[base].c, n_acc - 1);
    check("load_count", load_count, n_acc);
    check("overflow",   overflow, exp_ovf);
    check("load_idle",  {busy, bus.ld_ready, cpu_hold_rst}, 3'b011);
    check("load_clr",   {done, timeout, cycles}, '0);
  endtask

  // Starts the loaded program and compares the outcome with the program walk
  task automatic run_prog(input bit smode);
    int exp_n, en_base, g;
    bit exp_to;
    walk(exp_n, exp_to);
    en_base   = en_cnt;
    start     = 1'b1;
    step_mode = smode;
    tick();
    start     = 1'b0;
    step_mode = ~smode;
    check("prime_ctl",  {cpu_hold_rst, cpu_en, busy}, 3'b111);
    check("prime_clr",  {done, timeout, cycles}, '0);
    tick();
    check("run_hold", cpu_hold_rst, 1'b0);
    if (!smode) begin
      check("run_first_en", cpu_en, exp_n > 0);
      for (int t = 0; t < 40 && done !== 1'b1; t++) begin
        step = 1'(($urandom_range(0, 1)));
        tick();
      end
      step = 1'b0;
    end else begin
      check("step_idle_en", cpu_en, 1'b0);
      for (int k = 1; k <= exp_n + 2; k++) begin
        g = $urandom_range(0, 2);
        repeat (g) tick();
        step = 1'b1;
        tick();
        step = 1'b0;
        check("step_cycles", cycles, (k < exp_n) ? k : exp_n);
      end
      tick();
      tick();
    end
    check("run_done",    done, 1'b1);
    check("run_cycles",  cycles, exp_n);
    check("run_timeout", timeout, exp_to);
    check("run_retired", en_cnt - en_base, exp_n);
    check("run_frozen",  {busy, cpu_hold_rst, cpu_en}, 3'b000);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", n_checks);
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    bit last;
    int base;
    rst          = 1'b0;
    start        = 1'b0;
    step_mode    = 1'b0;
    step         = 1'b0;
    bus.ld_valid = 1'b0;
    bus.ld_data  = '0;
    bus.ld_last  = 1'b0;
    repeat (3) tick();

    // Reset state
    check("rst_ld_ready", bus.ld_ready, 1'b1);
    check("rst_imem",     {bus.imem_we, bus.imem_addr, bus.imem_wdata}, '0);
    check("rst_hold",     cpu_hold_rst, 1'b1);
    check("rst_en",       cpu_en, 1'b0);
    check("rst_status",   {busy, done, timeout, overflow}, 4'b0000);
    check("rst_cycles",   cycles, 0);
    check("rst_lcount",   load_count, 0);
    rst = 1'b1;
    tick();

    // Back-to-back load of three NOPs and HALT, then free run and single-step
    pw[0] = 32'h11; pw[1] = 32'h22; pw[2] = 32'h33; pw[3] = HALT;
    load_prog(4, 1'b1, 1'b0, 1'b0, 1'b0);
    run_prog(1'b0);
    run_prog(1'b1);

    // Branch-to-self: cycle limit, then rerun from DONE
    pw[0] = BSELF;
    load_prog(1, 1'b1, 1'b0, 1'b0, 1'b0);
    run_prog(1'b0);
    run_prog(1'b0);

    // Memory overflow with start ignored during LOAD; fifth word opens the next load
    for (int i = 0; i < 5; i++) pw[i] = 32'hA0 + i;
    load_prog(5, 1'b0, 1'b0, 1'b0, 1'b1);
    pw[0] = 32'hA4;
    load_prog(1, 1'b1, 1'b0, 1'b1, 1'b0);

    // Randomized programs and run modes
    for (int it = 0; it < 16; it++) begin
      n    = $urandom_range(1, 5);
      last = (n < DEPTH) ? 1'b1 : 1'(($urandom_range(0, 1)));
      for (int i = 0; i < n; i++) begin
        case ($urandom_range(0, 9))
          0, 1:    pw[i] = HALT;
          2:       pw[i] = BSELF;
          default: pw[i] = $urandom() & 32'h7FFF_FFFF;
        endcase
      end
      load_prog(n, last, 1'(($urandom_range(0, 1))), 1'b0, 1'b0);
      run_prog(1'(($urandom_range(0, 1))));
    end

    // Reset in the middle of a run
    pw[0] = BSELF;
    load_prog(1, 1'b1, 1'b0, 1'b0, 1'b0);
    start     = 1'b1;
    step_mode = 1'b0;
    tick();
    start = 1'b0;
    for (int t = 0; t < 20 && cycles !== 2; t++) tick();
    check("mid_run_reach", cycles, 2);
    rst = 1'b0;
    tick();
    rst = 1'b1;
    check("mid_run_ctl",    {cpu_hold_rst, cpu_en, busy, bus.ld_ready}, 4'b1001);
    check("mid_run_clr",    {done, timeout, cycles}, '0);

    // Reset on the same edge as an accept: the write never happens
    base         = wq.size();
    bus.ld_valid = 1'b1;
    bus.ld_data  = 32'hDEAD_BEEF;
    bus.ld_last  = 1'b1;
    rst          = 1'b0;
    tick();
    bus.ld_valid = 1'b0;
    rst          = 1'b1;
    tick();
    tick();
    check("rst_drop_write", wq.size() - base, 0);
    check("rst_drop_lcount", load_count, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/kgprisc_run_ctrl.md
# kgprisc_run_ctrl

Run controller for the KGPRISC single-cycle core. It loads a program into instruction memory over a valid/ready stream and releases the core from reset. It then runs the core free-running or in single-step mode until a HALT word or a cycle limit. After stopping, it freezes the core so results can be inspected. It sits between the test/host interface and the `KGPRISC` top, driving the core's reset and clock-enable and owning the instruction-memory write port.

## Interface

- `ADDR_W`, 10: instruction-memory word-address width.
- `HALT_WORD`, 32'hFFFF_FFFF: instruction encoding that stops execution.
- `CNT_W`, 32: cycle-counter width.
- `MAX_CYCLES`, 100000: executed-cycle limit before forced stop.

- `clk` in 1: single clock. All state updates on the rising edge.
- `rst` in 1: synchronous, active-low reset.
- `ld_valid` in 1: load word valid.
- `ld_data` in 32: load word.
- `ld_last` in 1: marks final word of the program.
- `ld_ready` out 1: controller accepts a load word.
- `start` in 1: begin execution (sampled level; one cycle is enough).
- `step_mode` in 1: sampled at start. 1 selects single-step.
- `step` in 1: execute one instruction when in step mode.
- `instruction` in 32: current instruction from the core (combinational).
- `imem_we` out 1, `imem_addr` out ADDR_W, `imem_wdata` out 32: instruction-memory write port.
- `cpu_hold_rst` out 1: 1 holds the core in reset.
- `cpu_en` out 1: core clock enable. The core retires one instruction per edge with `cpu_en`=1.
- `busy` out 1, `done` out 1, `timeout` out 1, `overflow` out 1: status.
- `cycles` out CNT_W: instructions executed in the current run.
- `load_count` out ADDR_W+1: words written in the last load.

## Operation

- States: IDLE, LOAD, PRIME, RUN, STEP, DONE.
- `ld_ready` = 1 in IDLE, LOAD and DONE. Otherwise it is 0.
- Handshake: a word is accepted on an edge where `ld_valid` and `ld_ready` are both 1.

Load sequence:
- The first accept from IDLE or DONE writes address 0. It clears `load_count`, `done`, `timeout`, `overflow` and `cycles`, and enters LOAD.
- Each accept registers a write on the following cycle: `imem_we`=1, `imem_addr` = current pointer, `imem_wdata` = `ld_data`. The pointer and `load_count` then increment.
- An accept with `ld_last`=1 returns to IDLE after its write.
- Accepting the word at address 2^ADDR_W−1 without `ld_last` is treated as last and sets `overflow`=1.
- In LOAD, the core is held: `cpu_hold_rst`=1, `cpu_en`=0.

Start and run:
- `start` in IDLE or DONE enters PRIME. `start` in LOAD is ignored.
- PRIME lasts one cycle with `cpu_hold_rst`=1 and `cpu_en`=1, which resets the core PC. It clears `cycles`, `done` and `timeout`, and latches `step_mode`.
- PRIME then goes to RUN (latched step_mode=0) or STEP (latched step_mode=1).
- RUN: `cpu_en` = (`instruction` ≠ HALT_WORD). `cycles` increments on each edge with `cpu_en`=1.
- STEP: `cpu_en` = `step` && (`instruction` ≠ HALT_WORD). `cycles` increments the same way.

Stopping:
- Halt: in RUN or STEP, when `instruction` = HALT_WORD, the state goes to DONE. The HALT instruction is never executed.
- Timeout: an enabled edge that would make `cycles` equal MAX_CYCLES goes to DONE with `timeout`=1.
- DONE: `done`=1, `cpu_hold_rst`=0, `cpu_en`=0. The core is frozen and its outputs remain observable.
- `busy` = 1 in LOAD, PRIME, RUN and STEP.

## Timing

- Reset (rst=0 at an edge) puts every output in the following state from the next cycle:
  - state IDLE, `ld_ready`=1;
  - `imem_we`=0, `imem_addr`=0, `imem_wdata`=0;
  - `cpu_hold_rst`=1, `cpu_en`=0;
  - `busy`=0, `done`=0, `timeout`=0, `overflow`=0;
  - `cycles`=0, `load_count`=0.
- Reset mid-load or mid-run aborts immediately. No further `imem_we`. Any pending write is dropped.
- Load latency: accept at edge N gives `imem_we`=1 during cycle N+1. Sustained throughput is one word per cycle.
- Start latency: `start` at edge N gives PRIME in cycle N+1 and first `cpu_en` in RUN in cycle N+2.
- `cpu_en` in RUN/STEP is combinational from `instruction`/`step`. It is 0 in the same cycle HALT_WORD appears. DONE follows at the next edge.
- Simultaneous events:
  - `ld_valid` and `start` in IDLE/DONE: the load wins and `start` is ignored.
  - `step` and HALT in the same cycle: the halt wins and no instruction executes.
  - Halt and timeout on the same edge: the halt wins and `timeout`=0.
  - `step` while in RUN is ignored.
- `cycles` saturates at MAX_CYCLES. It never wraps.

## Test plan

- Load 4 words (0x11,0x22,0x33, HALT_WORD with `ld_last`) back-to-back -> `imem_we` high for 4 consecutive cycles at addr 0..3 with matching data. `load_count`=4, state IDLE, `ld_ready` stays 1.
- Load 3 NOPs + HALT, pulse `start` with step_mode=0 -> one PRIME cycle, `cpu_en`=1 for exactly 3 cycles, then `done`=1, `cycles`=3, `timeout`=0.
- Same program with step_mode=1, 5 `step` pulses spaced 3 cycles apart -> `cycles` goes 1,2,3 on the first three pulses. The 4th and 5th pulses produce no `cpu_en` and `done`=1 after the 4th.
- MAX_CYCLES=8, program with a branch-to-self loop -> `done`=1 and `timeout`=1 with `cycles`=8. A following `start` reruns with `cycles` cleared.
- ADDR_W=2, stream 5 words without `ld_last` -> 4 writes at addr 0..3, `overflow`=1, IDLE, 5th word waits until the next load. `ld_valid` together with `start` in IDLE -> load taken, no PRIME.
- Assert rst=0 during RUN at `cycles`=2 -> next cycle IDLE, `cpu_hold_rst`=1, `cpu_en`=0, `cycles`=0, `done`=0.
